// File: rtl/spi_master_slave.sv
// SPI master and echo slave joined on one clock, for loopback and bring-up.
// Latency: frame of WIDTH+1 cycles; data_out carries the slave byte one cycle after the last bit.
// No backpressure: frames run back-to-back while rst is low; data_in is sampled once per frame.
//
// Ports:
//   sclk     in   system/SPI clock, all flops rising-edge
//   rst      in   asynchronous active-high reset
//   data_in  in   byte to transmit, captured in IDLE at frame start
//   data_out out  byte received from the slave in the last completed frame
//   ss       out  slave select, active low
//   mosi     out  master-out serial data (0 while ss high)
//   miso     out  slave-out serial data (0 while ss high)
module spi_master_slave #(
    parameter int                WIDTH      = 8,
    parameter logic [WIDTH-1:0]  SLAVE_INIT = '0
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             ss,
    output logic             mosi,
    output logic             miso
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_tx;
    logic [WIDTH-1:0]   w_tx_nxt;
    // Only the low WIDTH-1 received bits are kept; the final bit goes straight
    // from miso into data_out on the last edge.
    logic [WIDTH-2:0]   r_rx;
    logic [WIDTH-2:0]   w_rx_nxt;
    logic [WIDTH-1:0]   w_rx_full;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cnt_nxt;
    logic               r_ss;
    logic               w_ss_nxt;
    logic [WIDTH-1:0]   r_data_out;
    logic [WIDTH-1:0]   w_data_out_nxt;
    logic [WIDTH-1:0]   r_slave;

    assign ss       = r_ss;
    assign data_out = r_data_out;
    assign mosi     = r_ss ? 1'b0 : r_tx[WIDTH-1];
    assign miso     = r_ss ? 1'b0 : r_slave[WIDTH-1];

    assign w_rx_full = {r_rx, miso};

    // Master next-state and datapath
    always_comb begin
        w_state_nxt    = r_state;
        w_tx_nxt       = r_tx;
        w_rx_nxt       = r_rx;
        w_cnt_nxt      = r_cnt;
        w_ss_nxt       = r_ss;
        w_data_out_nxt = r_data_out;
        case (r_state)
            ST_IDLE: begin
                w_tx_nxt    = data_in;
                w_cnt_nxt   = '0;
                w_ss_nxt    = 1'b0;
                w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                w_tx_nxt  = r_tx << 1;
                w_rx_nxt  = w_rx_full[WIDTH-2:0];
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == CW'(WIDTH-1)) begin
                    w_data_out_nxt = w_rx_full;
                    w_ss_nxt       = 1'b1;
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_tx       <= '0;
            r_rx       <= '0;
            r_cnt      <= '0;
            r_ss       <= 1'b1;
            r_data_out <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx       <= w_tx_nxt;
            r_rx       <= w_rx_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ss       <= w_ss_nxt;
            r_data_out <= w_data_out_nxt;
        end
    end

    // Slave: shifts in mosi on the same edge the master samples miso; both see
    // the pre-edge values, so the echo is one frame behind.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_slave <= SLAVE_INIT;
        end else if (!r_ss) begin
            r_slave <= {r_slave[WIDTH-2:0], mosi};
        end
    end

endmodule

// File: tb/tb_spi_master_slave.sv
module tb_spi_master_slave;

    localparam logic [7:0] INIT1 = 8'hA5;

    logic       sclk = 1'b0;
    logic       rst  = 1'b1;
    logic [7:0] data_in = 8'hEA;

    logic [7:0] dout0, dout1;
    logic       ss0, ss1, mosi0, mosi1, miso0, miso1;

    spi_master_slave #(.WIDTH(8)) dut0 (
        .sclk(sclk), .rst(rst), .data_in(data_in), .data_out(dout0),
        .ss(ss0), .mosi(mosi0), .miso(miso0)
    );

    spi_master_slave #(.WIDTH(8), .SLAVE_INIT(INIT1)) dut1 (
        .sclk(sclk), .rst(rst), .data_in(data_in), .data_out(dout1),
        .ss(ss1), .mosi(mosi1), .miso(miso1)
    );

    always #5 sclk = ~sclk;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: frames of 9 edges after reset release. Edge 9k latches
    // the frame byte; after edge 9k+j (j<8) bit 7-j is on the wire; after edge
    // 9k+8 the frame is complete and the slave holds this frame's byte.
    int         n;
    int         frame_idx;
    logic [7:0] last_din, cur, prev0, prev1, exp_d0, exp_d1;
    logic [7:0] frame_tab [4] = '{8'hEA, 8'hEA, 8'h5A, 8'hFF};

    task automatic model_reset();
        n         = -1;
        cur       = 8'h00;
        prev0     = 8'h00;
        prev1     = INIT1;
        exp_d0    = 8'h00;
        exp_d1    = 8'h00;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ss0"},   ss0,   1'b1);
        check_val({tag, "_ss1"},   ss1,   1'b1);
        check_val({tag, "_mosi"},  mosi0, 1'b0);
        check_val({tag, "_miso0"}, miso0, 1'b0);
        check_val({tag, "_miso1"}, miso1, 1'b0);
        check_val({tag, "_dout0"}, dout0, 8'h00);
        check_val({tag, "_dout1"}, dout1, 8'h00);
    endtask

    task automatic check_outputs();
        int   ph;
        logic e_ss, e_mosi, e_miso0, e_miso1;
        if (n < 0 || (n % 9) == 8) begin
            e_ss = 1'b1; e_mosi = 1'b0; e_miso0 = 1'b0; e_miso1 = 1'b0;
        end else begin
            ph      = n % 9;
            e_ss    = 1'b0;
            e_mosi  = cur[7-ph];
            e_miso0 = prev0[7-ph];
            e_miso1 = prev1[7-ph];
        end
        check_val("ss0",   ss0,   e_ss);
        check_val("ss1",   ss1,   e_ss);
        check_val("mosi0", mosi0, e_mosi);
        check_val("mosi1", mosi1, e_mosi);
        check_val("miso0", miso0, e_miso0);
        check_val("miso1", miso1, e_miso1);
        check_val("dout0", dout0, exp_d0);
        check_val("dout1", dout1, exp_d1);
    endtask

    // Choose data_in for the coming edge: a frame byte at frame start,
    // otherwise junk (often 0) that must be ignored.
    task automatic drive_next();
        if (((n + 1) % 9) == 0) begin
            data_in = (frame_idx < 4) ? frame_tab[frame_idx] : 8'($urandom);
            frame_idx++;
        end else begin
            data_in = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
        end
        last_din = data_in;
    endtask

    // Called at a falling edge: account for the rising edge just taken.
    task automatic step();
        int ph;
        @(negedge sclk);
        n++;
        ph = n % 9;
        if (ph == 0) cur = last_din;
        if (ph == 8) begin
            exp_d0 = prev0;
            exp_d1 = prev1;
            prev0  = cur;
            prev1  = cur;
        end
        check_outputs();
        drive_next();
    endtask

    initial begin
        frame_idx = 0;
        model_reset();
        last_din = 8'hEA;

        // Reset hold for 250 time units
        repeat (25) begin
            @(negedge sclk);
            check_reset_outputs("rst_hold");
        end

        // Release at a falling edge; next rising edge is E0
        rst = 1'b0;
        model_reset();
        drive_next();
        repeat (9 * 6) step();

        // Advance to the point right after bit 3 has shifted, then reset
        while ((n % 9) != 4) step();
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        repeat (2) begin
            @(negedge sclk);
            check_reset_outputs("rst_mid");
        end

        rst = 1'b0;
        model_reset();
        drive_next();
        repeat (9 * 10 + 3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
